// File: rtl/sdram_arb_pkg.sv
// SDRAM arbiter shared definitions.
// Controller commands, arbiter states and slot event offsets.
package sdram_arb_pkg;

    localparam int AW = 24;
    localparam int DW = 16;

    typedef enum logic [1:0] {
        CMD_NOP,
        CMD_READ,
        CMD_WRITE,
        CMD_REFRESH
    } cmd_e;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_BUSY
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VID,
        OWN_CPU
    } owner_e;

    localparam int SC_STROBE = 0;
    localparam int SC_CAP    = 10;

endpackage

// File: rtl/sdram_arb_if.sv
// SDRAM arbiter bus bundle.
// slave = arbiter view, master = clients/controller view.
interface sdram_arb_if;
    import sdram_arb_pkg::*;

    logic          ready;
    logic          cpuRd;
    logic          cpuWr;
    logic [AW-1:0] cpuA;
    logic [DW-1:0] cpuDi;
    logic [DW-1:0] cpuDo;
    logic          cpuAck;
    logic          vidRd;
    logic [AW-1:0] vidA;
    logic [DW-1:0] vidDo;
    logic          vidAck;
    logic          read;
    logic          write;
    logic          refresh;
    logic [AW-1:0] portA;
    logic [DW-1:0] portDi;
    logic [DW-1:0] portDo;

    modport slave (
        input  ready, cpuRd, cpuWr, cpuA, cpuDi,
        input  vidRd, vidA, portDo,
        output cpuDo, cpuAck, vidDo, vidAck,
        output read, write, refresh, portA, portDi
    );

    modport master (
        output ready, cpuRd, cpuWr, cpuA, cpuDi,
        output vidRd, vidA, portDo,
        input  cpuDo, cpuAck, vidDo, vidAck,
        input  read, write, refresh, portA, portDi
    );

endinterface

// File: rtl/sdram_arb.sv
// Fixed-priority SDRAM arbiter: refresh > video > cpu write > cpu read.
// Every grant owns the controller for SLOT clocks.
module sdram_arb
    import sdram_arb_pkg::*;
#(
    parameter int SLOT  = 12,
    parameter int RFINT = 390
) (
    input  logic       clock,
    input  logic       reset,
    sdram_arb_if.slave bus
);

    localparam int SCW = $clog2(SLOT);
    localparam int RCW = $clog2(RFINT);
    localparam logic [SCW-1:0] SC_LAST = SCW'(SLOT - 1);
    localparam logic [RCW-1:0] RC_LAST = RCW'(RFINT - 1);

    state_e        st_q, st_d;
    logic [SCW-1:0] sc_q, sc_d;
    logic [RCW-1:0] rc_q, rc_d;
    logic          pend_q, pend_d;
    cmd_e          cmd_q, cmd_d;
    owner_e        own_q, own_d;
    logic [AW-1:0] a_q, a_d;
    logic [DW-1:0] di_q, di_d;
    logic [DW-1:0] cdo_q, cdo_d;
    logic [DW-1:0] vdo_q, vdo_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic          rf_q, rf_d;
    logic          cack_q, cack_d;
    logic          vack_q, vack_d;
    logic          wrap;
    logic          arb;

    // Next state; outputs are registered from the next slot count
    // so each strobe/ack lands in the cycle carrying that sc value.
    always_comb begin
        st_d   = st_q;
        sc_d   = sc_q;
        rc_d   = rc_q;
        pend_d = pend_q;
        cmd_d  = cmd_q;
        own_d  = own_q;
        a_d    = a_q;
        di_d   = di_q;
        cdo_d  = cdo_q;
        vdo_d  = vdo_q;
        rd_d   = 1'b1;
        wr_d   = 1'b1;
        rf_d   = 1'b1;
        cack_d = 1'b0;
        vack_d = 1'b0;
        wrap   = 1'b0;

        if (st_q == ST_INIT) begin
            rc_d = '0;
        end else if (rc_q == RC_LAST) begin
            rc_d = '0;
            wrap = 1'b1;
        end else begin
            rc_d = rc_q + 1'b1;
        end
        if (wrap) pend_d = 1'b1;

        // The last slot clock arbitrates like IDLE so slots can abut.
        arb = (st_q == ST_IDLE) ||
              (st_q == ST_BUSY && sc_q == SC_LAST);

        if (!bus.ready) begin
            st_d = ST_INIT;
            sc_d = '0;
        end else if (st_q == ST_INIT) begin
            st_d = ST_IDLE;
        end else if (arb) begin
            st_d = ST_IDLE;
            sc_d = SCW'(SC_STROBE);
            if (pend_q) begin
                st_d   = ST_BUSY;
                pend_d = wrap;
                cmd_d  = CMD_REFRESH;
                own_d  = OWN_NONE;
                rf_d   = 1'b0;
            end else if (bus.vidRd) begin
                st_d  = ST_BUSY;
                cmd_d = CMD_READ;
                own_d = OWN_VID;
                a_d   = bus.vidA;
                rd_d  = 1'b0;
            end else if (bus.cpuWr) begin
                st_d  = ST_BUSY;
                cmd_d = CMD_WRITE;
                own_d = OWN_CPU;
                a_d   = bus.cpuA;
                di_d  = bus.cpuDi;
                wr_d  = 1'b0;
            end else if (bus.cpuRd) begin
                st_d  = ST_BUSY;
                cmd_d = CMD_READ;
                own_d = OWN_CPU;
                a_d   = bus.cpuA;
                rd_d  = 1'b0;
            end
        end else if (st_q == ST_BUSY) begin
            sc_d = sc_q + 1'b1;
        end

        if (st_d == ST_BUSY && sc_d == SCW'(SC_CAP)) begin
            unique case (own_q)
                OWN_VID: begin
                    vack_d = 1'b1;
                    vdo_d  = bus.portDo;
                end
                OWN_CPU: begin
                    cack_d = 1'b1;
                    if (cmd_q == CMD_READ) cdo_d = bus.portDo;
                end
                default: ;
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            st_q   <= ST_INIT;
            sc_q   <= '0;
            rc_q   <= '0;
            pend_q <= 1'b0;
            cmd_q  <= CMD_NOP;
            own_q  <= OWN_NONE;
            a_q    <= '0;
            di_q   <= '0;
            cdo_q  <= '0;
            vdo_q  <= '0;
            rd_q   <= 1'b1;
            wr_q   <= 1'b1;
            rf_q   <= 1'b1;
            cack_q <= 1'b0;
            vack_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            sc_q   <= sc_d;
            rc_q   <= rc_d;
            pend_q <= pend_d;
            cmd_q  <= cmd_d;
            own_q  <= own_d;
            a_q    <= a_d;
            di_q   <= di_d;
            cdo_q  <= cdo_d;
            vdo_q  <= vdo_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            rf_q   <= rf_d;
            cack_q <= cack_d;
            vack_q <= vack_d;
        end
    end

    assign bus.read    = rd_q;
    assign bus.write   = wr_q;
    assign bus.refresh = rf_q;
    assign bus.portA   = a_q;
    assign bus.portDi  = di_q;
    assign bus.cpuDo   = cdo_q;
    assign bus.vidDo   = vdo_q;
    assign bus.cpuAck  = cack_q;
    assign bus.vidAck  = vack_q;

endmodule

// File: tb/tb_sdram_arb.sv
// Directed bench for sdram_arb.
// Instance a uses RFINT=390, instance b RFINT=20.
module tb_sdram_arb;
    import sdram_arb_pkg::*;

    logic clock = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clock = ~clock;

    sdram_arb_if a_if();
    sdram_arb_if b_if();

    sdram_arb u_a (
        .clock(clock),
        .reset(rst_a),
        .bus  (a_if)
    );

    sdram_arb #(.SLOT(12), .RFINT(20)) u_b (
        .clock(clock),
        .reset(rst_b),
        .bus  (b_if)
    );

    int n_vec = 0;
    int n_err = 0;
    int t_rd, t_wr, t_rf, t_cack, t_vack;
    int n_rd, n_wr, n_rf, n_cack, n_vack;
    int rf_t[8];

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Run n clocks on one instance; k=0 is the first edge.
    task automatic watch(input bit sel, input int n);
        logic rd, wr, rf, ca, va;
        t_rd = -1; t_wr = -1; t_rf = -1;
        t_cack = -1; t_vack = -1;
        n_rd = 0; n_wr = 0; n_rf = 0;
        n_cack = 0; n_vack = 0;
        for (int i = 0; i < 8; i++) rf_t[i] = -1;
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            rd = sel ? b_if.read    : a_if.read;
            wr = sel ? b_if.write   : a_if.write;
            rf = sel ? b_if.refresh : a_if.refresh;
            ca = sel ? b_if.cpuAck  : a_if.cpuAck;
            va = sel ? b_if.vidAck  : a_if.vidAck;
            if (!rd) begin
                if (t_rd < 0) t_rd = k;
                n_rd++;
            end
            if (!wr) begin
                if (t_wr < 0) t_wr = k;
                n_wr++;
            end
            if (!rf) begin
                if (t_rf < 0) t_rf = k;
                if (n_rf < 8) rf_t[n_rf] = k;
                n_rf++;
            end
            if (ca) begin
                if (t_cack < 0) t_cack = k;
                n_cack++;
                if (sel) begin
                    b_if.cpuRd = 1'b0;
                    b_if.cpuWr = 1'b0;
                end else begin
                    a_if.cpuRd = 1'b0;
                    a_if.cpuWr = 1'b0;
                end
            end
            if (va) begin
                if (t_vack < 0) t_vack = k;
                n_vack++;
                if (sel) b_if.vidRd = 1'b0;
                else     a_if.vidRd = 1'b0;
            end
        end
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        a_if.ready = 1'b0; b_if.ready = 1'b0;
        a_if.cpuRd = 1'b0; b_if.cpuRd = 1'b0;
        a_if.cpuWr = 1'b0; b_if.cpuWr = 1'b0;
        a_if.vidRd = 1'b0; b_if.vidRd = 1'b0;
        a_if.cpuA  = '0;   b_if.cpuA  = '0;
        a_if.cpuDi = '0;   b_if.cpuDi = '0;
        a_if.vidA  = '0;   b_if.vidA  = '0;
        a_if.portDo = '0;  b_if.portDo = '0;

        watch(0, 3);
        chk("rst_read",    32'(a_if.read),    32'd1);
        chk("rst_write",   32'(a_if.write),   32'd1);
        chk("rst_refresh", 32'(a_if.refresh), 32'd1);
        chk("rst_cpuAck",  32'(a_if.cpuAck),  32'd0);
        chk("rst_vidAck",  32'(a_if.vidAck),  32'd0);
        chk("rst_cpuDo",   32'(a_if.cpuDo),   32'h0);
        chk("rst_vidDo",   32'(a_if.vidDo),   32'h0);
        chk("rst_portA",   32'(a_if.portA),   32'h0);
        chk("rst_portDi",  32'(a_if.portDi),  32'h0);
        chk("rst_state",   32'(u_a.st_q),     32'(ST_INIT));
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Periodic refresh, RFINT=20, no requests.
        b_if.ready = 1'b1;
        watch(1, 100);
        chk("rf_count", n_rf, 4);
        chk("rf_first", rf_t[0], 21);
        chk("rf_gap1",  rf_t[1] - rf_t[0], 20);
        chk("rf_gap2",  rf_t[2] - rf_t[1], 20);
        chk("rf_gap3",  rf_t[3] - rf_t[2], 20);
        chk("rf_noack", n_cack + n_vack, 0);
        chk("rf_nord",  n_rd + n_wr, 0);

        // Refresh pending beats a waiting cpu read.
        watch(1, 1);
        b_if.cpuRd  = 1'b1;
        b_if.cpuA   = 24'h000ABC;
        b_if.portDo = 16'h5A5A;
        watch(1, 24);
        chk("rp_rf_at",  t_rf, 0);
        chk("rp_rf_n",   n_rf, 1);
        chk("rp_rd_at",  t_rd, 12);
        chk("rp_ack_at", t_cack, 22);
        chk("rp_cpuDo",  32'(b_if.cpuDo), 32'h5A5A);
        chk("rp_portA",  32'(b_if.portA), 32'h000ABC);

        // Single cpu read.
        a_if.ready = 1'b1;
        watch(0, 1);
        chk("init_idle", 32'(u_a.st_q), 32'(ST_IDLE));
        a_if.cpuRd  = 1'b1;
        a_if.cpuA   = 24'h000123;
        a_if.portDo = 16'hBEEF;
        watch(0, 14);
        chk("rd_strobe_at", t_rd, 0);
        chk("rd_strobe_n",  n_rd, 1);
        chk("rd_ack_at",    t_cack, 10);
        chk("rd_ack_n",     n_cack, 1);
        chk("rd_cpuDo",     32'(a_if.cpuDo), 32'hBEEF);
        chk("rd_portA",     32'(a_if.portA), 32'h000123);

        // Video and cpu write together: video first.
        a_if.vidRd  = 1'b1;
        a_if.vidA   = 24'h000456;
        a_if.cpuWr  = 1'b1;
        a_if.cpuA   = 24'h000789;
        a_if.cpuDi  = 16'h1234;
        a_if.portDo = 16'hCAFE;
        watch(0, 26);
        chk("vw_rd_at",   t_rd, 0);
        chk("vw_vack_at", t_vack, 10);
        chk("vw_wr_at",   t_wr, 12);
        chk("vw_cack_at", t_cack, 22);
        chk("vw_rd_n",    n_rd, 1);
        chk("vw_wr_n",    n_wr, 1);
        chk("vw_vidDo",   32'(a_if.vidDo), 32'hCAFE);
        chk("vw_cpuDo",   32'(a_if.cpuDo), 32'hBEEF);
        chk("vw_portA",   32'(a_if.portA), 32'h000789);
        chk("vw_portDi",  32'(a_if.portDi), 32'h1234);

        // Reset at sc=5 of a cpu write.
        a_if.cpuWr = 1'b1;
        a_if.cpuA  = 24'h000321;
        a_if.cpuDi = 16'h4321;
        watch(0, 6);
        chk("mr_wr_at", t_wr, 0);
        rst_a = 1'b0;
        watch(0, 3);
        chk("mr_ack_n",   n_cack, 0);
        chk("mr_read",    32'(a_if.read),    32'd1);
        chk("mr_write",   32'(a_if.write),   32'd1);
        chk("mr_refresh", 32'(a_if.refresh), 32'd1);
        chk("mr_state",   32'(u_a.st_q), 32'(ST_INIT));
        chk("mr_portA",   32'(a_if.portA), 32'h0);
        a_if.cpuWr = 1'b0;
        rst_a = 1'b1;
        watch(0, 12);
        chk("mr_after_ack", n_cack, 0);
        chk("mr_after_wr",  n_wr, 0);
        chk("mr_idle", 32'(u_a.st_q), 32'(ST_IDLE));

        // Ready falls at sc=3 of a cpu read.
        a_if.cpuRd  = 1'b1;
        a_if.cpuA   = 24'h000777;
        a_if.portDo = 16'h7777;
        watch(0, 4);
        chk("rf3_rd_at", t_rd, 0);
        a_if.ready = 1'b0;
        watch(0, 1);
        chk("rf3_init", 32'(u_a.st_q), 32'(ST_INIT));
        watch(0, 15);
        chk("rf3_quiet", n_rd + n_wr + n_rf, 0);
        chk("rf3_noack", n_cack, 0);
        chk("rf3_hold",  32'(u_a.st_q), 32'(ST_INIT));
        a_if.ready = 1'b1;
        watch(0, 14);
        chk("rf3_rd_again", t_rd, 1);
        chk("rf3_ack_at",   t_cack, 11);
        chk("rf3_cpuDo",    32'(a_if.cpuDo), 32'h7777);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sdram_arb.md
SDRAM_ARB -- requirements
Module: sdram_arb

Interface
REQ-001 SHALL have parameter SLOT, default 12, meaning clocks per granted access (min 12).
REQ-002 SHALL have parameter RFINT, default 390, meaning clocks between refresh requests.
REQ-003 SHALL have port clock  in  1  system clock, also the SDRAM controller clock.
REQ-004 SHALL have port reset  in  1  synchronous, active-low.
REQ-005 SHALL have port ready  in  1  controller init-done flag.
REQ-006 SHALL have port cpuRd, cpuWr  in  1 each  CPU level requests, held until cpuAck.
REQ-007 SHALL have port cpuA  in  24  CPU word address.
REQ-008 SHALL have port cpuDi  in  16  CPU write data.
REQ-009 SHALL have port cpuDo  out  16  CPU read data.
REQ-010 SHALL have port cpuAck  out  1  one-clock completion pulse.
REQ-011 SHALL have port vidRd  in  1  video level read request.
REQ-012 SHALL have port vidA  in  24  video word address.
REQ-013 SHALL have port vidDo  out  16  video read data.
REQ-014 SHALL have port vidAck  out  1  one-clock completion pulse.
REQ-015 SHALL have ports read, write, refresh  out  1 each  controller strobes, idle high, active-low pulse.
REQ-016 SHALL have port portA  out  24  controller address.
REQ-017 SHALL have port portDi  out  16  controller write data.
REQ-018 SHALL have port portDo  in  16  controller read data.

Function
REQ-019 SHALL implement states INIT, IDLE, BUSY; INIT->IDLE when ready=1; any state->INIT when ready=0, all strobes high next clock.
REQ-020 SHALL run a refresh counter 0..RFINT-1 in all states except INIT; on wrap set rfPend; a wrap while rfPend=1 leaves rfPend set (no queueing).
REQ-021 SHALL arbitrate in IDLE with fixed priority rfPend > vidRd > cpuWr > cpuRd; grant -> BUSY, slot counter sc=0.
REQ-022 SHALL drive the granted strobe low for exactly one clock at sc=0, high otherwise.
REQ-023 SHALL register portA (and portDi for writes) at grant and hold them stable until sc=SLOT-1.
REQ-024 SHALL clear rfPend at grant of a refresh slot; refresh slots produce no ack.
REQ-025 SHALL capture portDo into vidDo or cpuDo at sc=10 for read slots.
REQ-026 SHALL pulse the owning ack at sc=10 for read and write slots; vidDo/cpuDo hold value until the next capture.
REQ-027 SHALL return to IDLE at sc=SLOT-1; earliest next strobe at sc=SLOT of previous slot.
REQ-028 SHALL treat cpuRd and cpuWr both high as write.
REQ-029 SHALL ignore request changes during BUSY; a request dropped before grant is not serviced.
REQ-030 SHALL sample requests in IDLE only; the clock a request becomes high is the earliest grant clock.

Reset
REQ-031 SHALL on reset=0: state INIT, sc=0, refresh counter 0, rfPend 0, read/write/refresh 1, cpuAck/vidAck 0, cpuDo/vidDo/portA/portDi 0.
REQ-032 SHALL abandon any slot on reset mid-operation with no ack issued.

Structure
REQ-033 SHALL place state encodings and slot offsets (strobe at sc=0, capture/ack at sc=10) in the shared sdram package beside the controller command definitions.
REQ-034 SHALL contain no sub-module; the refresh timer is inline.

Verification
REQ-035 SHALL test: ready rises, cpuRd=1, cpuA=0x000123, portDo=0xBEEF -> read low one clock, portA=0x000123, cpuAck at grant+10, cpuDo=0xBEEF.
REQ-036 SHALL test: vidRd and cpuWr both high in IDLE -> video slot first, write strobe at video grant+12, cpuAck at video grant+22.
REQ-037 SHALL test: RFINT=20, no requests -> refresh low one clock every 20 clocks, no acks.
REQ-038 SHALL test: rfPend set and cpuRd pending -> refresh slot first, CPU read strobe 12 clocks later.
REQ-039 SHALL test: reset=0 at sc=5 of a CPU write -> all strobes high, cpuAck never pulses, state INIT.
REQ-040 SHALL test: ready falls at sc=3 -> INIT next clock, no ack, no strobe until ready returns.
